// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: four-state micro-op executor driving an external 8x4 register file
module regfile_op_sequencer #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic [DW-1:0] in_imm,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          flag_z,
    output logic          flag_c
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_MOV = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q, rs1_q, rs2_q;
    logic [DW-1:0] imm_q, opa_q, opb_q, res_q, res_d;
    logic          c_q, c_d, z_q;
    logic [DW:0]   sum, diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (in_valid ? READ : IDLE) :
                  state_q == READ ? EXEC :
                  state_q == EXEC ? WB : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                imm_q <= in_imm;
            end
            if (state_q == READ) begin
                opa_q <= rf_rdata1;
                opb_q <= rf_rdata2;
            end
            // result and flags only change here, so they hold between write-backs
            if (state_q == EXEC) begin
                res_q <= res_d;
                c_q   <= c_d;
                z_q   <= res_d == '0;
            end
        end
    end

    always_comb begin
        sum  = {1'b0, opa_q} + {1'b0, opb_q};
        diff = {1'b0, opa_q} - {1'b0, opb_q};
        res_d = diff[DW-1:0];
        c_d   = 1'b0;
        case (op_q)
            OP_ADD: begin res_d = sum[DW-1:0]; c_d = sum[DW]; end
            OP_SUB: begin res_d = diff[DW-1:0]; c_d = diff[DW]; end
            OP_AND: res_d = opa_q & opb_q;
            OP_OR:  res_d = opa_q | opb_q;
            OP_XOR: res_d = opa_q ^ opb_q;
            OP_LDI: res_d = imm_q;
            OP_MOV: res_d = opa_q;
            OP_CMP: begin res_d = diff[DW-1:0]; c_d = diff[DW]; end
            default: res_d = diff[DW-1:0];
        endcase
    end

    // write enable decodes from state so an async reset kills it immediately
    assign in_ready  = state_q == IDLE;
    assign rf_we     = state_q == WB && op_q != OP_CMP;
    assign rf_waddr  = rd_q;
    assign rf_wdata  = res_q;
    assign rf_raddr1 = rs1_q;
    assign rf_raddr2 = rs2_q;
    assign res_valid = state_q == WB;
    assign res_data  = res_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb_regfile_op_sequencer: randomized scoreboard bench with a behavioural register-file/ALU model
module tb_regfile_op_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op, in_rd, in_rs1, in_rs2;
    logic [3:0] in_imm;
    logic       rf_we;
    logic [2:0] rf_waddr, rf_raddr1, rf_raddr2;
    logic [3:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic       res_valid;
    logic [3:0] res_data;
    logic       flag_z, flag_c;

    regfile_op_sequencer #(.DW(4), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .res_valid(res_valid), .res_data(res_data), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    // the register file the sequencer drives
    logic [3:0] rf [8] = '{default: 4'd0};
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

    typedef struct {
        logic [3:0] res;
        logic       z, c, we;
        logic [2:0] rd;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [3:0] ref_rf [8] = '{default: 4'd0};
    int         errors = 0, checks = 0, cyc = 0, busy = 0;
    logic [3:0] last_res;
    logic       last_z, last_c;

    always @(posedge clk) cyc <= cyc + 1;

    // an accepted instruction keeps the sequencer busy for the next three cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          busy <= 0;
        else if (busy != 0)  busy <= busy - 1;
        else if (in_valid)   busy <= 3;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, rd, rs1, rs2, input logic [3:0] imm);
        exp_t x;
        int a, b, r;
        a = int'(ref_rf[rs1]);
        b = int'(ref_rf[rs2]);
        x.c = 1'b0;
        case (op)
            3'd0: begin r = a + b; x.c = r > 15; end
            3'd1: begin r = a - b; x.c = a < b; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = int'(imm);
            3'd6: r = a;
            default: begin r = a - b; x.c = a < b; end
        endcase
        r = r & 15;
        x.res = 4'(r);
        x.z = r == 0;
        x.we = op != 3'd7;
        x.rd = rd;
        x.cyc = 0;
        return x;
    endfunction

    task automatic send(input logic [2:0] op, rd, rs1, rs2, input logic [3:0] imm, output int acc);
        bit ok = 0;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin
                acc = cyc + 1;
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: in_ready stayed %0d, required 1", in_ready);
        end
    endtask

    task automatic issue(input logic [2:0] op, rd, rs1, rs2, input logic [3:0] imm, output int acc);
        exp_t x;
        x = model(op, rd, rs1, rs2, imm);
        send(op, rd, rs1, rs2, imm, acc);
        x.cyc = acc;
        sb.push_back(x);
        if (x.we) ref_rf[rd] = x.res;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_rf_we"}, int'(rf_we), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_data"}, int'(res_data), 0);
        chk({tag, "_flag_z"}, int'(flag_z), 0);
        chk({tag, "_flag_c"}, int'(flag_c), 0);
        chk({tag, "_addrs"}, int'({rf_waddr, rf_raddr1, rf_raddr2}), 0);
        chk({tag, "_wdata"}, int'(rf_wdata), 0);
    endtask

    // monitor: retirements, write-enable placement, output hold and ready timing
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res = 4'd0; last_z = 1'b0; last_c = 1'b0;
        end else begin
            chk("in_ready", int'(in_ready), int'(busy == 0));
            if (rf_we && !res_valid) chk("rf_we_outside_wb", int'(rf_we), 0);
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", int'(res_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("retire_cycle", cyc, e.cyc + 2);
                    chk("res_data", int'(res_data), int'(e.res));
                    chk("flags_zc", int'({flag_z, flag_c}), int'({e.z, e.c}));
                    chk("rf_we", int'(rf_we), int'(e.we));
                    if (e.we) chk("rf_write", int'({rf_waddr, rf_wdata}), int'({e.rd, e.res}));
                end
                last_res = res_data; last_z = flag_z; last_c = flag_c;
            end else begin
                chk("result_hold", int'({res_data, flag_z, flag_c}), int'({last_res, last_z, last_c}));
            end
        end
    end

    initial begin
        int a0, a1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        issue(3'd5, 3'd3, 3'd0, 3'd0, 4'd9, a0);
        issue(3'd5, 3'd5, 3'd0, 3'd0, 4'd8, a0);
        issue(3'd0, 3'd1, 3'd3, 3'd5, 4'd0, a0);
        issue(3'd6, 3'd2, 3'd1, 3'd0, 4'd0, a0);
        issue(3'd1, 3'd4, 3'd5, 3'd3, 4'd0, a0);
        issue(3'd7, 3'd6, 3'd3, 3'd3, 4'd0, a0);
        drain();

        issue(3'd5, 3'd3, 3'd0, 3'd0, 4'd5, a0);
        issue(3'd0, 3'd3, 3'd3, 3'd3, 4'd0, a1);
        chk("back_to_back_spacing", a1 - a0, 4);
        drain();

        send(3'd4, 3'd7, 3'd3, 3'd5, 4'd0, a0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midop_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(3'd6, 3'd2, 3'd7, 3'd0, 4'd0, a0);
        drain();

        for (int i = 0; i < 8; i++) issue(3'd5, 3'(i), 3'd0, 3'd0, 4'(i), a0);
        for (int i = 0; i < 8; i++) issue(3'd6, 3'(i), 3'(i), 3'd0, 4'd0, a0);
        drain();

        for (int n = 0; n < 300; n++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), a0);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        drain();
        for (int i = 0; i < 8; i++) chk("final_regfile", int'(rf[i]), int'(ref_rf[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
